// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decoded ID-side fields in, registered EX-side fields and
// the hazard stall out. The stage itself is the slave; whatever sits upstream
// (IF/ID register + decoder) and downstream (EX) together act as master.
//
// Handshake: there is no valid/ready pair here. 'stall' is a combinational
// hold request back to PC and IF/ID for the current cycle, and 'redirect_ok'
// is its complement, used to gate pcsrc/jump. An EX entry with every control
// bit at 0 and ex_writereg=0 is a bubble.
interface id_ex_stage_if #(
    parameter int DW = 32
);
    // ID side
    logic [31:0]   id_instr;
    logic [DW-1:0] id_pcplus4;
    logic [DW-1:0] id_rd1;
    logic [DW-1:0] id_rd2;
    logic [DW-1:0] id_imm;
    logic          id_regwrite;
    logic          id_memtoreg;
    logic          id_memwrite;
    logic          id_alusrc;
    logic          id_regdst;
    logic          id_jump;
    logic [2:0]    id_alucontrol;

    // Hazard control back to the front end
    logic          stall;
    logic          redirect_ok;

    // EX side
    logic          ex_regwrite;
    logic          ex_memtoreg;
    logic          ex_memwrite;
    logic          ex_alusrc;
    logic          ex_jump;
    logic [2:0]    ex_alucontrol;
    logic [DW-1:0] ex_rd1;
    logic [DW-1:0] ex_rd2;
    logic [DW-1:0] ex_imm;
    logic [DW-1:0] ex_pcplus4;
    logic [4:0]    ex_rs;
    logic [4:0]    ex_rt;
    logic [4:0]    ex_writereg;

    modport master (
        output id_instr, id_pcplus4, id_rd1, id_rd2, id_imm,
        output id_regwrite, id_memtoreg, id_memwrite, id_alusrc, id_regdst, id_jump,
        output id_alucontrol,
        input  stall, redirect_ok,
        input  ex_regwrite, ex_memtoreg, ex_memwrite, ex_alusrc, ex_jump, ex_alucontrol,
        input  ex_rd1, ex_rd2, ex_imm, ex_pcplus4, ex_rs, ex_rt, ex_writereg
    );

    modport slave (
        input  id_instr, id_pcplus4, id_rd1, id_rd2, id_imm,
        input  id_regwrite, id_memtoreg, id_memwrite, id_alusrc, id_regdst, id_jump,
        input  id_alucontrol,
        output stall, redirect_ok,
        output ex_regwrite, ex_memtoreg, ex_memwrite, ex_alusrc, ex_jump, ex_alucontrol,
        output ex_rd1, ex_rd2, ex_imm, ex_pcplus4, ex_rs, ex_rt, ex_writereg
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use and branch/jr-use hazard detection.
// A hazard loads one bubble into EX and holds the front end for that cycle;
// mem_busy freezes EX entirely. Two saturating counters track hazard stalls
// and inserted bubbles.
module id_ex_stage #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    id_ex_stage_if.slave     bus,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef struct packed {
        logic          regwrite;
        logic          memtoreg;
        logic          memwrite;
        logic          alusrc;
        logic          jump;
        logic [2:0]    alucontrol;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [DW-1:0] pcplus4;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    writereg;
    } ex_t;

    ex_t              ex_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] dest;
    logic       uses_rs;
    logic       uses_rt;
    logic       src_match;
    logic       is_branch;
    logic       ex_writes;
    logic       load_use;
    logic       br_use;
    logic       hazard;
    logic       bubble_load;

    // Shamt field is never looked at by this stage.
    logic unused_shamt;
    assign unused_shamt = ^bus.id_instr[10:6];

    // Decode the ID instruction and detect hazards against the current EX entry.
    always_comb begin
        op    = bus.id_instr[31:26];
        rs    = bus.id_instr[25:21];
        rt    = bus.id_instr[20:16];
        rd    = bus.id_instr[15:11];
        funct = bus.id_instr[5:0];

        // jal always links into $31, regardless of regdst.
        if (op == OP_JAL) begin
            dest = 5'd31;
        end else if (bus.id_regdst) begin
            dest = rd;
        end else begin
            dest = rt;
        end

        uses_rs   = !((op == OP_J) || (op == OP_JAL) || (op == OP_LUI));
        uses_rt   = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
        src_match = (uses_rs && (ex_q.writereg == rs)) || (uses_rt && (ex_q.writereg == rt));
        is_branch = (op == OP_BEQ) || (op == OP_BNE) || ((op == OP_RTYPE) && (funct == FN_JR));

        // A write to $0 is discarded, so it never creates a dependency.
        ex_writes = ex_q.regwrite && (ex_q.writereg != 5'd0);
        load_use  = ex_writes && ex_q.memtoreg && src_match;
        br_use    = ex_writes && is_branch && src_match;
        hazard    = load_use || br_use;

        // mem_busy outranks the hazard: nothing moves, the hazard is seen again next cycle.
        bubble_load = hazard && !mem_busy;
    end

    // Select the next EX entry: hold, bubble or capture.
    always_comb begin
        ex_d = ex_q;
        if (!mem_busy) begin
            if (hazard) begin
                ex_d = '0;
            end else begin
                ex_d.regwrite   = bus.id_regwrite;
                ex_d.memtoreg   = bus.id_memtoreg;
                ex_d.memwrite   = bus.id_memwrite;
                ex_d.alusrc     = bus.id_alusrc;
                ex_d.jump       = bus.id_jump;
                ex_d.alucontrol = bus.id_alucontrol;
                ex_d.rd1        = bus.id_rd1;
                ex_d.rd2        = bus.id_rd2;
                ex_d.imm        = bus.id_imm;
                ex_d.pcplus4    = bus.id_pcplus4;
                ex_d.rs         = rs;
                ex_d.rt         = rt;
                ex_d.writereg   = dest;
            end
        end
    end

    // Saturating performance counters; clear takes priority over counting.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (hazard && !mem_busy && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (bubble_load && (bubble_cnt_q != '1)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    // EX register and counter state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q         <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.stall         = hazard || mem_busy;
    assign bus.redirect_ok   = !(hazard || mem_busy);

    assign bus.ex_regwrite   = ex_q.regwrite;
    assign bus.ex_memtoreg   = ex_q.memtoreg;
    assign bus.ex_memwrite   = ex_q.memwrite;
    assign bus.ex_alusrc     = ex_q.alusrc;
    assign bus.ex_jump       = ex_q.jump;
    assign bus.ex_alucontrol = ex_q.alucontrol;
    assign bus.ex_rd1        = ex_q.rd1;
    assign bus.ex_rd2        = ex_q.rd2;
    assign bus.ex_imm        = ex_q.imm;
    assign bus.ex_pcplus4    = ex_q.pcplus4;
    assign bus.ex_rs         = ex_q.rs;
    assign bus.ex_rt         = ex_q.rt;
    assign bus.ex_writereg   = ex_q.writereg;

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
endmodule
